simpletest_operand_stager: RTL and testbench

- Upstream feeder for the simpletest datapath (op1/op2/sel_r/key consumer).
- Accepts raw byte pairs over a valid/ready handshake and routes them per `sel` into op1/op2.
- Buffers routed pairs in a small FIFO and presents them downstream over valid/ready.
- Gates issue until a serially loaded lock key is complete.

---
 rtl/simpletest_pkg.sv | 17 +
 rtl/simpletest_pair_fifo.sv | 76 +++++++
 rtl/simpletest_operand_stager.sv | 111 +++++++++++
 tb/tb_simpletest_operand_stager.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/simpletest_pkg.sv
// Shared encodings for the simpletest operand stager: sel routing codes,
// key-load FSM states and the default operand width.
package simpletest_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] SEL_PASS = 2'd0;
  localparam logic [1:0] SEL_SWAP = 2'd1;
  localparam logic [1:0] SEL_DUP1 = 2'd2;
  localparam logic [1:0] SEL_DUP2 = 2'd3;

  typedef enum logic {
    KEY_LOAD = 1'b0,
    RUN      = 1'b1
  } state_t;

endpackage

// File: rtl/simpletest_pair_fifo.sv
// Synchronous FIFO for routed operand pairs. The head entry is held in its own
// register so the outputs never expose a combinational path from the write side.
module simpletest_pair_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = cnt_q;
  assign rdata   = head_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head tracks what will sit at rptr after this cycle; it holds when the FIFO drains.
    if (empty && push_ok) begin
      head_d = wdata;
    end else if (pop_ok && cnt_q == CW'(1)) begin
      if (push_ok) head_d = wdata;
    end else if (pop_ok) begin
      head_d = mem_q[rptr_q + 1'b1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/simpletest_operand_stager.sv
// Operand stager: serial lock-key loader gating a sel-routed pair FIFO that
// feeds the simpletest datapath over valid/ready.
module simpletest_operand_stager
  import simpletest_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2,
  parameter int KEY_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              key_load,
  input  logic              key_bit,
  output logic [KEY_W-1:0]  key,
  output logic              key_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        sel_r
);

  localparam int KCW = $clog2(KEY_W) + 1;
  localparam int EW  = 2 + 2 * DATA_W;
  localparam int CW  = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KCW-1:0]    kcnt_q, kcnt_d;
  logic              key_done_q, key_done_d;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [EW-1:0]     rdata;
  logic [CW-1:0]     count;
  logic              full, empty;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    kcnt_d     = kcnt_q;
    key_done_d = key_done_q;
    case (state_q)
      KEY_LOAD: begin
        if (key_load) begin
          key_d  = {key_q[KEY_W-2:0], key_bit};
          kcnt_d = kcnt_q + 1'b1;
          if (kcnt_q == KCW'(KEY_W - 1)) begin
            state_d    = RUN;
            key_done_d = 1'b1;
          end
        end
      end
      default: ;  // RUN: key frozen until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= KEY_LOAD;
      key_q      <= '0;
      kcnt_q     <= '0;
      key_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      kcnt_q     <= kcnt_d;
      key_done_q <= key_done_d;
    end
  end

  always_comb begin
    r_op1 = in1;
    r_op2 = in2;
    case (sel)
      SEL_PASS: begin r_op1 = in1; r_op2 = in2; end
      SEL_SWAP: begin r_op1 = in2; r_op2 = in1; end
      SEL_DUP1: begin r_op1 = in1; r_op2 = in1; end
      SEL_DUP2: begin r_op1 = in2; r_op2 = in2; end
      default:  ;
    endcase
  end

  assign in_ready = (state_q == RUN) && !full;

  simpletest_pair_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (out_valid && out_ready),
    .wdata ({sel, r_op1, r_op2}),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign {sel_r, op1, op2} = rdata;
  assign key      = key_q;
  assign key_done = key_done_q;

  a_in_hold: assert property (@(posedge clk) disable iff (!rst)
    in_valid && !in_ready |=> in_valid && $stable({sel, in1, in2}));
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_simpletest_operand_stager.sv
// Scoreboard bench for simpletest_operand_stager: directed pushes enqueue
// hand-computed pairs, a negedge monitor compares every popped head.
module tb_simpletest_operand_stager;

  logic       clk = 1'b0, rst = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [1:0] sel = '0;
  logic [7:0] in1 = '0, in2 = '0;
  logic       key_load = 1'b0, key_bit = 1'b0;
  logic [3:0] key;
  logic       key_done, out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] op1, op2;
  logic [1:0] sel_r;

  int n_cmp = 0, n_fail = 0;
  logic [17:0] sb[$];

  simpletest_operand_stager #(.DATA_W(8), .DEPTH(2), .KEY_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .in1(in1), .in2(in2), .key_load(key_load), .key_bit(key_bit), .key(key),
    .key_done(key_done), .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .sel_r(sel_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a pair and wait (bounded) for acceptance; returns at posedge+1
  // with in_valid still high so the caller may chain back-to-back pushes.
  task automatic send(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e1, input logic [7:0] e2, input bit steady);
    int budget = 20;
    in_valid = 1'b1; sel = s; in1 = a; in2 = b;
    @(negedge clk);
    if (steady) begin
      chk("steady_in_ready", in_ready, 1);
      chk("steady_out_valid", out_valid, 1);
    end
    while (!in_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      tick;
      return;
    end
    sb.push_back({s, e1, e2});
    tick;
  endtask

  task automatic load_key(input logic [3:0] k);
    for (int i = 3; i >= 0; i--) begin
      key_load = 1'b1; key_bit = k[i];
      @(negedge clk);
      chk("pre_load_key_done", key_done, 0);
      chk("pre_load_in_ready", in_ready, 0);
      tick;
    end
    key_load = 1'b0;
    @(negedge clk);
    chk("loaded_key", key, k);
    chk("loaded_key_done", key_done, 1);
    chk("loaded_in_ready", in_ready, 1);
    tick;
  endtask

  task automatic drain;
    int b = 0;
    while (sb.size() > 0 && b < 20) begin
      tick;
      b++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {sel_r, op1, op2}, 32'hFFFF_FFFF);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        chk("pop_pair", {sel_r, op1, op2}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick;
    chk("rst_key", key, 0);
    chk("rst_key_done", key_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ops", {sel_r, op1, op2}, 0);
    rst = 1'b1;
    tick;

    load_key(4'b1011);

    // Routing: each sel with 0x12/0x34, visible the cycle after push
    out_ready = 1'b1;
    send(2'd0, 8'h12, 8'h34, 8'h12, 8'h34, 0); in_valid = 1'b0;
    @(negedge clk); chk("lat_sel0", out_valid, 1); tick;
    send(2'd1, 8'h12, 8'h34, 8'h34, 8'h12, 0); in_valid = 1'b0;
    @(negedge clk); chk("lat_sel1", out_valid, 1); tick;
    send(2'd2, 8'h12, 8'h34, 8'h12, 8'h12, 0); in_valid = 1'b0;
    @(negedge clk); chk("lat_sel2", out_valid, 1); tick;
    send(2'd3, 8'h12, 8'h34, 8'h34, 8'h34, 0); in_valid = 1'b0;
    @(negedge clk); chk("lat_sel3", out_valid, 1); tick;
    drain;

    // Backpressure: fill, hold a third pair while full, then release
    out_ready = 1'b0;
    send(2'd0, 8'hA1, 8'hB1, 8'hA1, 8'hB1, 0);
    send(2'd0, 8'hA2, 8'hB2, 8'hA2, 8'hB2, 0);
    in1 = 8'hA3; in2 = 8'hB3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", {op1, op2}, 16'hA1B1);
      tick;
    end
    out_ready = 1'b1;
    send(2'd0, 8'hA3, 8'hB3, 8'hA3, 8'hB3, 0);
    in_valid = 1'b0;
    drain;

    // Steady push+pop at count=1 with incrementing in1
    send(2'd0, 8'h40, 8'h5A, 8'h40, 8'h5A, 0);
    for (int i = 1; i <= 10; i++)
      send(2'd0, 8'h40 + 8'(i), 8'h5A, 8'h40 + 8'(i), 8'h5A, 1);
    in_valid = 1'b0;
    drain;

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    send(2'd1, 8'h11, 8'h22, 8'h22, 8'h11, 0);
    send(2'd2, 8'h33, 8'h44, 8'h33, 8'h33, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_op1", op1, 0);
    chk("arst_key", key, 0);
    chk("arst_key_done", key_done, 0);
    chk("arst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 0);
      tick;
    end
    load_key(4'b0110);

    // key_load strobes in RUN are ignored
    for (int i = 0; i < 4; i++) begin
      key_load = 1'b1; key_bit = 1'b0;
      tick;
    end
    key_load = 1'b0;
    @(negedge clk);
    chk("run_key_frozen", key, 4'b0110);
    chk("run_key_done", key_done, 1);
    tick;

    out_ready = 1'b1;
    send(2'd3, 8'hC3, 8'h3C, 8'h3C, 8'h3C, 0);
    in_valid = 1'b0;
    drain;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
